// File: rtl/alu_iterative.sv
// Execute-stage integer ALU: single-cycle RV32I ops plus iterative unsigned
// multiply/divide, with registered result/flags and valid/ready on both sides.
module alu_iterative #(
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUctrl,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  LT,
  output logic                  LTU
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  localparam logic [SHAMT_WIDTH-1:0] LAST_CNT = SHAMT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_iter(input logic [3:0] ctrl);
    is_iter = (ctrl == OP_MUL) || (ctrl == OP_MULHU) ||
              (ctrl == OP_DIVU) || (ctrl == OP_REMU);
  endfunction

  function automatic logic is_mul(input logic [3:0] ctrl);
    is_mul = (ctrl == OP_MUL) || (ctrl == OP_MULHU);
  endfunction

  // {EQ, LT, LTU} for a pair of operands
  function automatic logic [2:0] cmp_flags(input logic [DATA_WIDTH-1:0] a,
                                           input logic [DATA_WIDTH-1:0] b);
    cmp_flags = {(a == b), ($signed(a) < $signed(b)), (a < b)};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu_single(input logic [3:0]            ctrl,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    logic [SHAMT_WIDTH-1:0] sh;
    sh = b[SHAMT_WIDTH-1:0];
    case (ctrl)
      OP_ADD:  alu_single = a + b;
      OP_SUB:  alu_single = a - b;
      OP_AND:  alu_single = a & b;
      OP_OR:   alu_single = a | b;
      OP_XOR:  alu_single = a ^ b;
      OP_SLL:  alu_single = a << sh;
      OP_SRL:  alu_single = a >> sh;
      OP_SRA:  alu_single = $unsigned($signed(a) >>> sh);
      OP_SLT:  alu_single = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_single = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: alu_single = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic                      valid_r;
  logic [3:0]                op_r;
  logic [DATA_WIDTH-1:0]     a_r;
  logic [DATA_WIDTH-1:0]     b_r;
  logic [2*DATA_WIDTH-1:0]   work_r;
  logic [SHAMT_WIDTH-1:0]    cnt_r;
  logic [DATA_WIDTH-1:0]     result_r;
  logic                      eq_r;
  logic                      lt_r;
  logic                      ltu_r;

  logic                      accept_s;
  logic                      last_s;
  logic [DATA_WIDTH:0]       mul_sum_s;
  logic [DATA_WIDTH:0]       div_shift_s;
  logic                      div_ge_s;
  logic [DATA_WIDTH-1:0]     div_diff_s;
  logic [DATA_WIDTH-1:0]     div_rem_s;
  logic [2*DATA_WIDTH-1:0]   step_next_s;
  logic [DATA_WIDTH-1:0]     iter_result_s;

  assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign last_s    = (state_r == ST_BUSY) && (cnt_r == LAST_CNT);
  assign out_valid = valid_r;
  assign ALUout    = result_r;
  assign EQ        = eq_r;
  assign LT        = lt_r;
  assign LTU       = ltu_r;

  // Next-state decode; a consume in DONE re-enters as an IDLE acceptance
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = is_iter(ALUctrl) ? ST_BUSY : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready && in_valid) begin
          state_next_s = is_iter(ALUctrl) ? ST_BUSY : ST_DONE;
        end else if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // One shift-add multiply step or one restoring-divide step on work_r.
  // Divide by zero needs no special case: every trial subtract succeeds,
  // so the quotient fills with ones and the dividend shifts into the remainder.
  always_comb begin
    mul_sum_s     = {1'b0, work_r[2*DATA_WIDTH-1:DATA_WIDTH]} +
                    (work_r[0] ? {1'b0, a_r} : {(DATA_WIDTH+1){1'b0}});
    div_shift_s   = {work_r[2*DATA_WIDTH-1:DATA_WIDTH], work_r[DATA_WIDTH-1]};
    div_ge_s      = (div_shift_s >= {1'b0, b_r});
    div_diff_s    = div_shift_s[DATA_WIDTH-1:0] - b_r;
    div_rem_s     = div_ge_s ? div_diff_s : div_shift_s[DATA_WIDTH-1:0];
    step_next_s   = {2*DATA_WIDTH{1'b0}};
    iter_result_s = {DATA_WIDTH{1'b0}};
    if (is_mul(op_r)) begin
      step_next_s = {mul_sum_s, work_r[DATA_WIDTH-1:1]};
    end else begin
      step_next_s = {div_rem_s, work_r[DATA_WIDTH-2:0], div_ge_s};
    end
    if ((op_r == OP_MUL) || (op_r == OP_DIVU)) begin
      iter_result_s = step_next_s[DATA_WIDTH-1:0];
    end else begin
      iter_result_s = step_next_s[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // State and out_valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, iteration datapath and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 4'b0000;
      a_r      <= {DATA_WIDTH{1'b0}};
      b_r      <= {DATA_WIDTH{1'b0}};
      work_r   <= {2*DATA_WIDTH{1'b0}};
      cnt_r    <= {SHAMT_WIDTH{1'b0}};
      result_r <= {DATA_WIDTH{1'b0}};
      eq_r     <= 1'b0;
      lt_r     <= 1'b0;
      ltu_r    <= 1'b0;
    end else if (accept_s) begin
      op_r  <= ALUctrl;
      a_r   <= ALUop1;
      b_r   <= ALUop2;
      cnt_r <= {SHAMT_WIDTH{1'b0}};
      if (is_iter(ALUctrl)) begin
        work_r <= is_mul(ALUctrl) ? {{DATA_WIDTH{1'b0}}, ALUop2}
                                  : {{DATA_WIDTH{1'b0}}, ALUop1};
      end else begin
        result_r              <= alu_single(ALUctrl, ALUop1, ALUop2);
        {eq_r, lt_r, ltu_r}   <= cmp_flags(ALUop1, ALUop2);
      end
    end else if (state_r == ST_BUSY) begin
      work_r <= step_next_s;
      cnt_r  <= cnt_r + SHAMT_WIDTH'(1);
      if (last_s) begin
        result_r            <= iter_result_s;
        {eq_r, lt_r, ltu_r} <= cmp_flags(a_r, b_r);
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative at DATA_WIDTH 32 and 8.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] ALUop1, ALUop2, ALUout;
  logic        EQ, LT, LTU;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  ALUctrl8;
  logic [7:0]  ALUop1_8, ALUop2_8, ALUout8;
  logic        EQ8, LT8, LTU8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2),
    .out_valid(out_valid), .out_ready(out_ready), .ALUout(ALUout),
    .EQ(EQ), .LT(LT), .LTU(LTU));

  alu_iterative #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUctrl(ALUctrl8), .ALUop1(ALUop1_8), .ALUop2(ALUop2_8),
    .out_valid(out_valid8), .out_ready(out_ready8), .ALUout(ALUout8),
    .EQ(EQ8), .LT(LT8), .LTU(LTU8));

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec32_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [2:0] fl;
  } vec8_t;

  // Present one request, let the next edge accept it, then scramble the inputs
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    ALUctrl = c; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ALUctrl = 4'b0000; ALUop1 = 32'hDEAD_BEEF; ALUop2 = 32'h0BAD_F00D;
  endtask

  task automatic issue8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    ALUctrl8 = c; ALUop1_8 = a; ALUop2_8 = b; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; ALUctrl8 = 4'b0000; ALUop1_8 = 8'hA5; ALUop2_8 = 8'h5A;
  endtask

  task automatic consume;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic consume8;
    out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0; out_ready8 = 1'b0;
    ALUctrl = 4'b0000; ALUop1 = 32'd1; ALUop2 = 32'd1; in_valid = 1'b1;
    ALUctrl8 = 4'b0000; ALUop1_8 = 8'd1; ALUop2_8 = 8'd1; in_valid8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ALUout, EQ, LT, LTU} !== 36'd0) begin
      errors++;
      $display("FAIL reset32: valid=%b out=%h flags=%b%b%b required all zero", out_valid, ALUout, EQ, LT, LTU);
    end
    checks++;
    if ({out_valid8, ALUout8, EQ8, LT8, LTU8} !== 12'd0) begin
      errors++;
      $display("FAIL reset8: valid=%b out=%h flags=%b%b%b required all zero", out_valid8, ALUout8, EQ8, LT8, LTU8);
    end
    in_valid = 1'b0; in_valid8 = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready, in_ready8);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_single_cycle;
    vec32_t tbl [13];
    tbl = '{
      {4'b0000, 32'd5,         32'hFFFF_FFFD, 32'd2,         3'b001},
      {4'b0001, 32'd7,         32'd7,         32'd0,         3'b100},
      {4'b0001, 32'd0,         32'd1,         32'hFFFF_FFFF, 3'b011},
      {4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 3'b010},
      {4'b0011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 3'b010},
      {4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 3'b010},
      {4'b0101, 32'd1,         32'h0000_0021, 32'd2,         3'b011},
      {4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000, 3'b010},
      {4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 3'b010},
      {4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         3'b010},
      {4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd0,         3'b010},
      {4'b1110, 32'd3,         32'd3,         32'd0,         3'b100},
      {4'b1111, 32'd2,         32'd9,         32'd0,         3'b011}
    };
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].ctrl, tbl[i].a, tbl[i].b);
      checks++;
      if (out_valid !== 1'b1 || ALUout !== tbl[i].res) begin
        errors++;
        $display("FAIL single[%0d] ctrl=%b: valid=%b out=%h required valid=1 out=%h", i, tbl[i].ctrl, out_valid, ALUout, tbl[i].res);
      end
      checks++;
      if ({EQ, LT, LTU} !== tbl[i].fl) begin
        errors++;
        $display("FAIL single_flags[%0d]: got %b required %b", i, {EQ, LT, LTU}, tbl[i].fl);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_consume[%0d]: out_valid=%b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_iterative32;
    vec32_t tbl [6];
    int lat;
    bit busy_bad;
    tbl = '{
      {4'b1010, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 3'b011},
      {4'b1011, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001, 3'b011},
      {4'b1100, 32'd100,       32'd7,         32'd14,        3'b000},
      {4'b1101, 32'd100,       32'd7,         32'd2,         3'b000},
      {4'b1100, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 3'b000},
      {4'b1101, 32'h0000_1234, 32'd0,         32'h0000_1234, 3'b000}
    };
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].ctrl, tbl[i].a, tbl[i].b);
      // a competing request while BUSY must be ignored
      ALUctrl = 4'b0000; ALUop1 = 32'h11; ALUop2 = 32'h22; in_valid = 1'b1; out_ready = 1'b1;
      lat = 0; busy_bad = 1'b0;
      while (out_valid !== 1'b1 && lat < 100) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (lat != 32) begin
        errors++;
        $display("FAIL iter32_latency[%0d]: got %0d edges required 32", i, lat);
      end
      checks++;
      if (busy_bad) begin
        errors++;
        $display("FAIL iter32_busy_ready[%0d]: in_ready was 1 in BUSY, required 0", i);
      end
      checks++;
      if (ALUout !== tbl[i].res || {EQ, LT, LTU} !== tbl[i].fl) begin
        errors++;
        $display("FAIL iter32[%0d] ctrl=%b: out=%h flags=%b required out=%h flags=%b", i, tbl[i].ctrl, ALUout, {EQ, LT, LTU}, tbl[i].res, tbl[i].fl);
      end
      consume();
    end
  endtask

  task automatic test_iterative8;
    vec8_t tbl [8];
    int lat;
    tbl = '{
      {4'b1010, 8'h10, 8'h13, 8'h30, 3'b011},
      {4'b1011, 8'h10, 8'h13, 8'h01, 3'b011},
      {4'b1010, 8'hFF, 8'hFF, 8'h01, 3'b100},
      {4'b1011, 8'hFF, 8'hFF, 8'hFE, 3'b100},
      {4'b1100, 8'd100, 8'd7, 8'd14, 3'b000},
      {4'b1101, 8'd100, 8'd7, 8'd2,  3'b000},
      {4'b1100, 8'h34, 8'h00, 8'hFF, 3'b000},
      {4'b1101, 8'h34, 8'h00, 8'h34, 3'b000}
    };
    for (int i = 0; i < 8; i++) begin
      issue8(tbl[i].ctrl, tbl[i].a, tbl[i].b);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL iter8_latency[%0d]: got %0d edges required 8", i, lat);
      end
      checks++;
      if (ALUout8 !== tbl[i].res || {EQ8, LT8, LTU8} !== tbl[i].fl) begin
        errors++;
        $display("FAIL iter8[%0d] ctrl=%b: out=%h flags=%b required out=%h flags=%b", i, tbl[i].ctrl, ALUout8, {EQ8, LT8, LTU8}, tbl[i].res, tbl[i].fl);
      end
      consume8();
    end
  endtask

  task automatic test_back_to_back;
    issue(4'b0000, 32'h10, 32'h20);
    ALUctrl = 4'b0001; ALUop1 = 32'd9; ALUop2 = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, ALUout, EQ, LT, LTU} !== {1'b1, 1'b0, 32'h30, 3'b011}) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b ready=%b out=%h flags=%b required 1 0 00000030 011", i, out_valid, in_ready, ALUout, {EQ, LT, LTU});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUout !== 32'd5 || {EQ, LT, LTU} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_result: valid=%b out=%h flags=%b required 1 00000005 000", out_valid, ALUout, {EQ, LT, LTU});
    end
    consume();
  endtask

  task automatic test_async_reset;
    bit stray;
    issue(4'b1100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, ALUout, EQ, LT, LTU} !== 36'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b out=%h flags=%b required all zero", out_valid, ALUout, {EQ, LT, LTU});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL async_reset_discard: out_valid rose after reset, required 0");
    end
    issue(4'b0000, 32'd1, 32'd1);
    checks++;
    if (out_valid !== 1'b1 || ALUout !== 32'd2 || {EQ, LT, LTU} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_add: valid=%b out=%h flags=%b required 1 00000002 100", out_valid, ALUout, {EQ, LT, LTU});
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative32();
    test_iterative8();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
